// File: rtl/nec_operand_fetch_if.sv
// Operand fetch bus: decoder control, prefetch ring view, and assembled field results.
// master drives the requests and ring view; slave is the fetch unit.
interface nec_operand_fetch_if #(
    parameter int QUEUE_DEPTH = 8,
    parameter int QW          = $clog2(QUEUE_DEPTH)
);
    logic                        ce_1;
    logic                        ce_2;
    logic                        set_pc;
    logic [15:0]                 new_pc;
    logic                        start;
    logic [2:0]                  disp_size;
    logic [2:0]                  imm_size;
    logic                        disp_sext;
    logic                        retire;
    logic [QW:0]                 ipq_len;
    logic [QUEUE_DEPTH-1:0][7:0] ipq;
    logic [15:0]                 pc;
    logic [2:0]                  consumed;
    logic                        busy;
    logic                        done;
    logic [15:0]                 disp;
    logic [31:0]                 imm;
    logic                        size_err;

    modport master (
        output ce_1, ce_2, set_pc, new_pc, start, disp_size, imm_size, disp_sext,
               retire, ipq_len, ipq,
        input  pc, consumed, busy, done, disp, imm, size_err
    );

    modport slave (
        input  ce_1, ce_2, set_pc, new_pc, start, disp_size, imm_size, disp_sext,
               retire, ipq_len, ipq,
        output pc, consumed, busy, done, disp, imm, size_err
    );
endinterface

// File: rtl/nec_operand_fetch.sv
// Displacement/immediate extractor: pulls up to BYTES_PER_CYCLE trailing bytes per ce_1
// from the prefetch ring, spanning the disp/imm boundary, and owns the fetch pc.
module nec_operand_fetch #(
    parameter int QUEUE_DEPTH     = 8,
    parameter int BYTES_PER_CYCLE = 2,
    parameter int MAX_DISP        = 2,
    parameter int MAX_IMM         = 4
) (
    input logic                clk,
    input logic                reset_n,
    nec_operand_fetch_if.slave bus
);
    localparam int QW = $clog2(QUEUE_DEPTH);
    localparam logic [4:0] BPC_W = 5'(BYTES_PER_CYCLE);

    typedef enum logic [1:0] {S_IDLE, S_DISP, S_IMM, S_DONE} state_e;

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [2:0]  dr_q, dr_d;
    logic [2:0]  ir_q, ir_d;
    logic [2:0]  dsize_q, dsize_d;
    logic [2:0]  isize_q, isize_d;
    logic        sext_q, sext_d;
    logic [15:0] disp_q, disp_d;
    logic [31:0] imm_q, imm_d;
    logic        size_err_q, size_err_d;

    logic          fetching;
    logic          start_ok;
    logic          size_bad;
    logic [4:0]    take_w;
    logic [2:0]    take;
    logic [2:0]    off;
    logic [QW-1:0] idx;

    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        dr_d       = dr_q;
        ir_d       = ir_q;
        dsize_d    = dsize_q;
        isize_d    = isize_q;
        sext_d     = sext_q;
        disp_d     = disp_q;
        imm_d      = imm_q;
        size_err_d = size_err_q;
        off        = '0;
        idx        = '0;
        take       = '0;

        fetching = (state_q == S_DISP) || (state_q == S_IMM);
        take_w   = 5'(dr_q) + 5'(ir_q);
        if (5'(bus.ipq_len) < take_w) take_w = 5'(bus.ipq_len);
        if (BPC_W < take_w)           take_w = BPC_W;
        if (reset_n && bus.ce_1 && !bus.set_pc && fetching) take = take_w[2:0];

        start_ok = bus.ce_1 && bus.start &&
                   ((state_q == S_IDLE) || ((state_q == S_DONE) && bus.retire));
        size_bad = (bus.disp_size > 3'(MAX_DISP)) || (bus.imm_size > 3'(MAX_IMM));

        if ((bus.ce_1 || bus.ce_2) && bus.set_pc) begin
            pc_d    = bus.new_pc;
            state_d = S_IDLE;
            dr_d    = '0;
            ir_d    = '0;
        end else if (start_ok) begin
            if (size_bad) begin
                size_err_d = 1'b1;
            end else begin
                dr_d    = bus.disp_size;
                ir_d    = bus.imm_size;
                dsize_d = bus.disp_size;
                isize_d = bus.imm_size;
                sext_d  = bus.disp_sext;
                disp_d  = '0;
                imm_d   = '0;
                if (bus.disp_size != 3'd0)     state_d = S_DISP;
                else if (bus.imm_size != 3'd0) state_d = S_IMM;
                else                           state_d = S_DONE;
            end
        end else if (bus.ce_1 && (state_q == S_DONE) && bus.retire) begin
            state_d = S_IDLE;
        end else if (take != 3'd0) begin
            // Lanes below dr_q finish the displacement; the rest continue the immediate.
            for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
                if (3'(j) < take) begin
                    idx = pc_q[QW-1:0] + QW'(j);
                    if (3'(j) < dr_q) begin
                        off = dsize_q - dr_q + 3'(j);
                        disp_d[{off[0], 3'b000} +: 8] = bus.ipq[idx];
                    end else begin
                        off = isize_q - ir_q + 3'(j) - dr_q;
                        imm_d[{off[1:0], 3'b000} +: 8] = bus.ipq[idx];
                    end
                end
            end
            pc_d = pc_q + 16'(take);
            if (take >= dr_q) begin
                dr_d = '0;
                ir_d = ir_q - (take - dr_q);
                if ((dr_q != 3'd0) && (dsize_q == 3'd1) && sext_q) disp_d[15:8] = {8{disp_d[7]}};
            end else begin
                dr_d = dr_q - take;
            end
            if (dr_d != 3'd0)      state_d = S_DISP;
            else if (ir_d != 3'd0) state_d = S_IMM;
            else                   state_d = S_DONE;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            dr_q       <= '0;
            ir_q       <= '0;
            dsize_q    <= '0;
            isize_q    <= '0;
            sext_q     <= 1'b0;
            disp_q     <= '0;
            imm_q      <= '0;
            size_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            dr_q       <= dr_d;
            ir_q       <= ir_d;
            dsize_q    <= dsize_d;
            isize_q    <= isize_d;
            sext_q     <= sext_d;
            disp_q     <= disp_d;
            imm_q      <= imm_d;
            size_err_q <= size_err_d;
        end
    end

    assign bus.pc       = pc_q;
    assign bus.consumed = take;
    assign bus.busy     = fetching;
    assign bus.done     = (state_q == S_DONE) && !bus.set_pc;
    assign bus.disp     = disp_q;
    assign bus.imm      = imm_q;
    assign bus.size_err = size_err_q;
endmodule

// File: tb/tb_nec_operand_fetch.sv
// Scoreboard bench for nec_operand_fetch: directed corner cases, then randomized fetches
// checked against a byte-addressed memory model of the instruction stream.
module tb_nec_operand_fetch;
    localparam int QD  = 8;
    localparam int QW  = 3;
    localparam int BPC = 2;
    localparam int LW  = QW + 1;

    typedef struct packed {
        logic [15:0] disp;
        logic [31:0] imm;
        logic [15:0] pc;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    nec_operand_fetch_if #(.QUEUE_DEPTH(QD)) bus ();

    nec_operand_fetch #(
        .QUEUE_DEPTH(QD), .BYTES_PER_CYCLE(BPC), .MAX_DISP(2), .MAX_IMM(4)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    logic [7:0]  mem [0:65535];
    exp_t        exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    logic [15:0] model_pc;
    int          lens[5]  = '{0, 1, 0, 3, 3};
    int          cons[5]  = '{0, 1, 0, 2, 1};

    // The ring always shows the instruction stream starting at the current fetch pc.
    function automatic logic [QD-1:0][7:0] ring_view(input logic [15:0] p);
        logic [15:0] a;
        ring_view = '0;
        for (int k = 0; k < QD; k++) begin
            a = p + 16'(k);
            ring_view[a[QW-1:0]] = mem[a];
        end
    endfunction
    assign bus.ipq = ring_view(bus.pc);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues a start on ce_1; a valid one pushes the fields the stream holds at model_pc.
    task automatic do_start(input int d, input int i, input logic sx, input logic with_retire,
                            input logic valid);
        exp_t e;
        bus.start     = 1'b1;
        bus.ce_1      = 1'b1;
        bus.retire    = with_retire;
        bus.disp_size = 3'(d);
        bus.imm_size  = 3'(i);
        bus.disp_sext = sx;
        if (valid) begin
            e = '0;
            for (int k = 0; k < d; k++) e.disp[8*k +: 8] = mem[model_pc + 16'(k)];
            if (d == 1 && sx) e.disp[15:8] = {8{e.disp[7]}};
            for (int k = 0; k < i; k++) e.imm[8*k +: 8] = mem[model_pc + 16'(d + k)];
            model_pc = model_pc + 16'(d + i);
            e.pc = model_pc;
            exp_q.push_back(e);
        end
        step();
        bus.start  = 1'b0;
        bus.retire = 1'b0;
    endtask

    task automatic wait_done(input bit rand_inputs);
        int n = 0;
        while (!bus.done && n < 300) begin
            if (rand_inputs) begin
                bus.ce_1    = ($urandom_range(3) != 0);
                bus.ce_2    = 1'($urandom_range(1));
                bus.ipq_len = LW'($urandom_range(QD));
            end
            step();
            n++;
        end
        checks++;
        if (!bus.done) begin
            failures++;
            $display("FAIL done_timeout: got done=0 expected done=1 within 300 cycles");
        end
    endtask

    // Monitor: a new result is a rising done, or done still high after a retire fired.
    logic prev_done = 1'b0;
    logic prev_fire = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && bus.done && (!prev_done || prev_fire)) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result: got disp=0x%0h imm=0x%0h expected none",
                         bus.disp, bus.imm);
            end else begin
                e = exp_q.pop_front();
                check("res_disp", 32'(bus.disp), 32'(e.disp));
                check("res_imm", bus.imm, e.imm);
                check("res_pc", 32'(bus.pc), 32'(e.pc));
            end
        end
        prev_done <= reset_n && bus.done;
        prev_fire <= reset_n && bus.done && bus.ce_1 && bus.retire;
    end

    initial begin
        int  d;
        int  i;
        logic sx;
        bit  in_done;

        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        reset_n       = 1'b0;
        bus.ce_1      = 1'b0;
        bus.ce_2      = 1'b0;
        bus.set_pc    = 1'b0;
        bus.new_pc    = '0;
        bus.start     = 1'b0;
        bus.disp_size = '0;
        bus.imm_size  = '0;
        bus.disp_sext = 1'b0;
        bus.retire    = 1'b0;
        bus.ipq_len   = '0;
        model_pc      = '0;
        step();
        step();
        reset_n = 1'b1;
        check("rst_pc", 32'(bus.pc), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_consumed", 32'(bus.consumed), 0);
        check("rst_disp", 32'(bus.disp), 0);
        check("rst_imm", bus.imm, 0);
        check("rst_size_err", 32'(bus.size_err), 0);

        // Two-cycle fetch across the ring wrap 7 -> 0.
        mem[6] = 8'h34; mem[7] = 8'h12; mem[8] = 8'h78; mem[9] = 8'h56;
        mem[10] = 8'h80;
        mem[11] = 8'h01; mem[12] = 8'h02; mem[13] = 8'h03; mem[14] = 8'h04;
        mem[16'h1000] = 8'hA1; mem[16'h1001] = 8'hB2;
        mem[16'h1002] = 8'hC3; mem[16'h1003] = 8'hD4;
        bus.set_pc = 1'b1; bus.new_pc = 16'h0006; bus.ce_2 = 1'b1;
        step();
        bus.set_pc = 1'b0; bus.ce_2 = 1'b0;
        model_pc = 16'h0006;
        check("t1_pc_set", 32'(bus.pc), 32'h6);
        bus.ipq_len = LW'(8);
        do_start(2, 2, 1'b0, 1'b0, 1'b1);
        check("t1_busy", 32'(bus.busy), 1);
        check("t1_consumed0", 32'(bus.consumed), 2);
        step();
        check("t1_consumed1", 32'(bus.consumed), 2);
        step();
        check("t1_done", 32'(bus.done), 1);
        check("t1_disp", 32'(bus.disp), 32'h1234);
        check("t1_imm", bus.imm, 32'h5678);
        check("t1_pc", 32'(bus.pc), 32'hA);

        // Sign-extended one-byte displacement, started together with retire.
        do_start(1, 0, 1'b1, 1'b1, 1'b1);
        check("t2_consumed", 32'(bus.consumed), 1);
        step();
        check("t2_done", 32'(bus.done), 1);
        check("t2_disp", 32'(bus.disp), 32'hFF80);

        // Starved queue.
        bus.retire = 1'b1;
        step();
        bus.retire = 1'b0;
        check("t3_idle", 32'(bus.done), 0);
        bus.ipq_len = '0;
        do_start(0, 4, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            bus.ipq_len = LW'(lens[k]);
            #1;
            check($sformatf("t3_consumed%0d", k), 32'(bus.consumed), 32'(cons[k]));
            check($sformatf("t3_not_done%0d", k), 32'(bus.done), 0);
            step();
        end
        check("t3_done", 32'(bus.done), 1);
        check("t3_imm", bus.imm, 32'h04030201);

        // Retire plus zero-size start: fields cleared, done held.
        do_start(0, 0, 1'b0, 1'b1, 1'b1);
        check("t5_done", 32'(bus.done), 1);
        check("t5_disp", 32'(bus.disp), 0);
        check("t5_imm", bus.imm, 0);

        // Redirect mid-IMM on a phase-2 edge.
        bus.retire = 1'b1;
        step();
        bus.retire  = 1'b0;
        bus.ipq_len = '0;
        do_start(0, 4, 1'b0, 1'b0, 1'b1);
        step();
        check("t4_stalled", 32'(bus.busy), 1);
        bus.set_pc = 1'b1; bus.new_pc = 16'h1000; bus.ce_2 = 1'b1; bus.ipq_len = LW'(8);
        #1;
        check("t4_consumed", 32'(bus.consumed), 0);
        check("t4_done_low", 32'(bus.done), 0);
        step();
        bus.set_pc = 1'b0; bus.ce_2 = 1'b0;
        void'(exp_q.pop_back());
        model_pc = 16'h1000;
        check("t4_busy", 32'(bus.busy), 0);
        check("t4_done", 32'(bus.done), 0);
        check("t4_pc", 32'(bus.pc), 32'h1000);

        do_start(2, 2, 1'b0, 1'b0, 1'b1);
        wait_done(1'b0);
        check("t4b_disp", 32'(bus.disp), 32'hB2A1);
        check("t4b_imm", bus.imm, 32'hD4C3);
        bus.retire = 1'b1;
        step();
        bus.retire = 1'b0;

        // Oversized immediate is rejected.
        do_start(0, 5, 1'b0, 1'b0, 1'b0);
        check("t6_size_err", 32'(bus.size_err), 1);
        check("t6_busy", 32'(bus.busy), 0);
        check("t6_done", 32'(bus.done), 0);
        check("t6_pc", 32'(bus.pc), 32'h1004);

        // Reset while a fetch is stalled.
        bus.ipq_len = '0;
        do_start(0, 4, 1'b0, 1'b0, 1'b1);
        check("t7_busy", 32'(bus.busy), 1);
        reset_n = 1'b0; bus.ipq_len = LW'(8); bus.ce_1 = 1'b1;
        #1;
        check("t7_consumed_in_rst", 32'(bus.consumed), 0);
        step();
        check("t7_pc", 32'(bus.pc), 0);
        check("t7_busy_rst", 32'(bus.busy), 0);
        check("t7_done", 32'(bus.done), 0);
        check("t7_disp", 32'(bus.disp), 0);
        check("t7_imm", bus.imm, 0);
        check("t7_size_err", 32'(bus.size_err), 0);
        check("t7_consumed", 32'(bus.consumed), 0);
        reset_n = 1'b1;
        void'(exp_q.pop_back());
        model_pc = '0;

        // Randomized fetches with irregular ce_1, ce_2 and queue fill.
        in_done = 1'b0;
        for (int t = 0; t < 80; t++) begin
            d  = $urandom_range(2);
            i  = $urandom_range(4);
            sx = 1'($urandom_range(1));
            bus.ce_2    = 1'($urandom_range(1));
            bus.ipq_len = LW'($urandom_range(QD));
            do_start(d, i, sx, in_done, 1'b1);
            wait_done(1'b1);
            repeat ($urandom_range(2)) begin
                bus.ce_1 = 1'($urandom_range(1));
                bus.ce_2 = 1'($urandom_range(1));
                step();
            end
            if ($urandom_range(1) == 1) begin
                in_done = 1'b1;
            end else begin
                bus.ce_1   = 1'b1;
                bus.retire = 1'b1;
                step();
                bus.retire = 1'b0;
                check("rnd_retire_idle", 32'(bus.done), 0);
                in_done = 1'b0;
            end
        end
        bus.ce_1 = 1'b0;
        step();
        step();
        check("queue_drained", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
